// File: rtl/sc_io_selftest.sv
// sc_io_selftest -- loadable-vector self-test sequencer for the single-cycle computer.
//
// Each vector in the table is applied in four steps:
//   1. Drive the computer's input ports with the vector's input words.
//   2. Hold the computer in reset (dut_resetn low) for RST_CYCLES cycles.
//   3. Release reset and watch one output port for the expected value,
//      for at most TIMEOUT cycles.
//   4. Record whether the vector passed or failed.
//
// Build option:
//   SELFTEST_STABLE_EN -- when defined, a match must hold for 4 consecutive
//   RUN cycles before the vector passes. When undefined, a single matching
//   cycle is enough.
//
// Ports:
//   clock, resetn        system clock; asynchronous active-low reset
//   start, num_vec       start pulse; number of vectors to run (clamped to DEPTH)
//   ld_we, ld_addr,      table write: ld_sel 0..NCH-1 selects an input word,
//   ld_sel, ld_data      NCH the expected value, NCH+1 the output port select
//   out_port_bus         computer outputs; port k = bits [k*WIDTH +: WIDTH]
//   in_port_bus          computer inputs, packed the same way
//   dut_resetn           active-low reset to the computer
//   busy, done, pass     run status; pass is valid while done is high
//   fail_count           number of failing vectors
//   fail_index           index of the first failing vector
//
// State table:
//   IDLE  | waiting for start after reset
//   RESET | inputs applied, computer held in reset
//   RUN   | computer running, output port compared each cycle
//   DONE  | run finished, result held, computer left running
module sc_io_selftest #(
  parameter int WIDTH      = 32,
  parameter int NCH        = 2,
  parameter int NOUT       = 3,
  parameter int DEPTH      = 16,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     num_vec,
  input  logic                       ld_we,
  input  logic [$clog2(DEPTH)-1:0]   ld_addr,
  input  logic [$clog2(NCH+2)-1:0]   ld_sel,
  input  logic [WIDTH-1:0]           ld_data,
  input  logic [NOUT*WIDTH-1:0]      out_port_bus,
  output logic [NCH*WIDTH-1:0]       in_port_bus,
  output logic                       dut_resetn,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [$clog2(DEPTH):0]     fail_count,
  output logic [$clog2(DEPTH)-1:0]   fail_index
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(NCH + 2);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

  state_t          state;
  logic [AW-1:0]   vec_idx;
  logic [CW-1:0]   n_vec;
  logic [CW-1:0]   n_eff;
  logic [RW-1:0]   rst_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [CW-1:0]   fail_cnt;
  logic [AW-1:0]   fail_idx;
  logic            running;
  logic            match;
  logic            pass_now;
  logic            last_vec;

  // The vector table has no reset, so a reset does not clear loaded vectors.
  logic [WIDTH-1:0] tbl_in  [DEPTH][NCH];
  logic [WIDTH-1:0] tbl_exp [DEPTH];
  logic [WIDTH-1:0] tbl_sel [DEPTH];

  assign running  = (state == RESET) || (state == RUN);
  assign n_eff    = (num_vec > CW'(DEPTH)) ? CW'(DEPTH) : num_vec;
  assign last_vec = ({1'b0, vec_idx} == (n_vec - CW'(1)));

  always_ff @(posedge clock) begin
    if (ld_we && !running) begin
      for (int c = 0; c < NCH; c++)
        if (ld_sel == SW'(c)) tbl_in[ld_addr][c] <= ld_data;
      if (ld_sel == SW'(NCH))     tbl_exp[ld_addr] <= ld_data;
      if (ld_sel == SW'(NCH + 1)) tbl_sel[ld_addr] <= ld_data;
    end
  end

  // A select value of NOUT or above matches no port, so such a vector
  // can only end by timing out.
  always_comb begin
    match = 1'b0;
    for (int k = 0; k < NOUT; k++)
      if (tbl_sel[vec_idx] == WIDTH'(k) &&
          out_port_bus[k*WIDTH +: WIDTH] == tbl_exp[vec_idx])
        match = 1'b1;
  end

`ifdef SELFTEST_STABLE_EN
  logic [1:0] stab_cnt;
  assign pass_now = match && (stab_cnt == 2'd3);
`else
  assign pass_now = match;
`endif

  // Outputs are registered from the state one cycle later. As a result,
  // dut_resetn is low for exactly RST_CYCLES cycles per vector, and a match
  // at RUN count k is reported k+1 cycles after dut_resetn rises.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      vec_idx     <= '0;
      n_vec       <= '0;
      rst_cnt     <= '0;
      tmo_cnt     <= '0;
      fail_cnt    <= '0;
      fail_idx    <= '0;
      in_port_bus <= '0;
      dut_resetn  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_count  <= '0;
      fail_index  <= '0;
`ifdef SELFTEST_STABLE_EN
      stab_cnt    <= 2'd0;
`endif
    end else begin
      busy       <= running;
      done       <= (state == DONE);
      pass       <= (state == DONE) && (fail_cnt == '0);
      dut_resetn <= (state == RUN) || (state == DONE);
      fail_count <= fail_cnt;
      fail_index <= fail_idx;
      if (state == RESET)
        for (int c = 0; c < NCH; c++)
          in_port_bus[c*WIDTH +: WIDTH] <= tbl_in[vec_idx][c];

      case (state)
        IDLE, DONE: begin
          if (start) begin
            fail_cnt <= '0;
            fail_idx <= '0;
            vec_idx  <= '0;
            n_vec    <= n_eff;
            rst_cnt  <= RW'(RST_CYCLES - 1);
            state    <= (n_eff == '0) ? DONE : RESET;
          end
        end
        RESET: begin
          if (rst_cnt == '0) begin
            state   <= RUN;
            tmo_cnt <= TW'(TIMEOUT - 1);
`ifdef SELFTEST_STABLE_EN
            stab_cnt <= 2'd0;
`endif
          end else begin
            rst_cnt <= rst_cnt - RW'(1);
          end
        end
        RUN: begin
`ifdef SELFTEST_STABLE_EN
          stab_cnt <= match ? stab_cnt + 2'd1 : 2'd0;
`endif
          // A match on the final allowed cycle still counts as a pass.
          if (pass_now || tmo_cnt == '0) begin
            if (!pass_now) begin
              fail_cnt <= fail_cnt + CW'(1);
              if (fail_cnt == '0) fail_idx <= vec_idx;
            end
            if (last_vec) begin
              state <= DONE;
            end else begin
              state   <= RESET;
              vec_idx <= vec_idx + AW'(1);
              rst_cnt <= RW'(RST_CYCLES - 1);
            end
          end else begin
            tmo_cnt <= tmo_cnt - TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_io_selftest.sv
module tb_sc_io_selftest;
  localparam int WIDTH = 32, NCH = 2, NOUT = 3, DEPTH = 16, RST_CYCLES = 4, TIMEOUT = 64;
`ifdef SELFTEST_STABLE_EN
  localparam int STAB = 4;
`else
  localparam int STAB = 1;
`endif

  logic                  clock = 1'b0;
  logic                  resetn, start, ld_we;
  logic [4:0]            num_vec;
  logic [3:0]            ld_addr;
  logic [1:0]            ld_sel;
  logic [31:0]           ld_data;
  logic [NOUT*WIDTH-1:0] out_port_bus;
  logic [NCH*WIDTH-1:0]  in_port_bus;
  logic                  dut_resetn, busy, done, pass;
  logic [4:0]            fail_count;
  logic [3:0]            fail_index;

  int checks = 0;
  int errors = 0;

  sc_io_selftest #(.WIDTH(WIDTH), .NCH(NCH), .NOUT(NOUT), .DEPTH(DEPTH),
                   .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .resetn(resetn), .start(start), .num_vec(num_vec),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_sel(ld_sel), .ld_data(ld_data),
    .out_port_bus(out_port_bus), .in_port_bus(in_port_bus),
    .dut_resetn(dut_resetn), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .fail_index(fail_index));

  always #5 clock = ~clock;

  // Computer model: port k shows f_k(inputs) once it has run dly[k] cycles out of reset.
  int unsigned dly[3];
  bit          glitch_on = 1'b0;
  int unsigned glitch_at = 0;
  int unsigned cyc = 0;

  function automatic logic [31:0] f_of(input int k, input logic [31:0] a, input logic [31:0] b);
    case (k)
      0:       return 2 * a + b;
      1:       return a + 3 * b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [31:0] comp_out(input int k, input int unsigned c, input logic [31:0] a,
                                           input logic [31:0] b, input int unsigned d,
                                           input bit gon, input int unsigned gat);
    if (gon && k == 2)
      return ((c >= gat && c <= gat + 2) || c >= gat + 4) ? f_of(k, a, b) : 32'd0;
    return (c >= d) ? f_of(k, a, b) : 32'd0;
  endfunction

  always @(posedge clock) cyc <= dut_resetn ? cyc + 1 : 0;

  always_comb begin
    for (int k = 0; k < NOUT; k++)
      out_port_bus[k*WIDTH +: WIDTH] = comp_out(k, cyc, in_port_bus[31:0], in_port_bus[63:32],
                                                dly[k], glitch_on, glitch_at);
  end

  // Monitor: lengths of dut_resetn low / high stretches while busy.
  int hiq[$];
  int loq[$];
  int hi_n = 0, lo_n = 0;
  always @(negedge clock) begin
    if (busy && dut_resetn) begin
      if (lo_n > 0) loq.push_back(lo_n);
      lo_n = 0; hi_n++;
    end else if (busy) begin
      if (hi_n > 0) hiq.push_back(hi_n);
      hi_n = 0; lo_n++;
    end else begin
      if (hi_n > 0) hiq.push_back(hi_n);
      if (lo_n > 0) loq.push_back(lo_n);
      hi_n = 0; lo_n = 0;
    end
  end

  // Reference copy of the vector table.
  logic [31:0] m_in0[DEPTH], m_in1[DEPTH], m_exp[DEPTH], m_sel[DEPTH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // RUN cycles a vector should take, from the computer model and the stability rule.
  function automatic int predict(input int v, output bit ok);
    int          run;
    int unsigned c;
    logic [31:0] val;
    run = 0;
    ok  = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      c = (k == 0) ? 0 : k - 1;
      if (m_sel[v] < NOUT) begin
        val = comp_out(int'(m_sel[v]), c, m_in0[v], m_in1[v], dly[m_sel[v]], glitch_on, glitch_at);
        run = (val == m_exp[v]) ? run + 1 : 0;
      end
      if (run == STAB) begin
        ok = 1'b1;
        return k + 1;
      end
    end
    return TIMEOUT;
  endfunction

  task automatic tbl_write(input int a, input int s, input logic [31:0] d);
    @(negedge clock);
    ld_we = 1'b1; ld_addr = 4'(a); ld_sel = 2'(s); ld_data = d;
    @(negedge clock);
    ld_we = 1'b0;
  endtask

  task automatic load_vec(input int v, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e, input logic [31:0] s);
    m_in0[v] = a; m_in1[v] = b; m_exp[v] = e; m_sel[v] = s;
    tbl_write(v, 0, a);
    tbl_write(v, 1, b);
    tbl_write(v, 2, e);
    tbl_write(v, 3, s);
  endtask

  task automatic rand_vec(input int v);
    logic [31:0] a, b, s, e;
    a = $urandom_range(1, 500);
    b = $urandom_range(1, 500);
    s = $urandom_range(0, 5);
    if (s < 3 && $urandom_range(0, 3) != 0) e = f_of(int'(s), a, b);
    else e = 32'h8000_0000 | $urandom;
    load_vec(v, a, b, e, s);
  endtask

  task automatic launch(input int n);
    int ne;
    ne = (n > DEPTH) ? DEPTH : n;
    @(negedge clock);
    hiq.delete(); loq.delete();
    num_vec = 5'(n); start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_lag", busy, 0);
    @(negedge clock);
    if (ne > 0) begin
      check("start_busy", busy, 1);
      check("start_done", done, 0);
      check("start_dut_resetn", dut_resetn, 0);
      check("start_inputs", in_port_bus, {m_in1[0], m_in0[0]});
    end else begin
      check("empty_done", done, 1);
      check("empty_pass", pass, 1);
      check("empty_busy", busy, 0);
    end
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (done) break;
      @(negedge clock);
    end
    if (i == budget) check("done_timeout", 0, 1);
    @(negedge clock);
  endtask

  task automatic check_run(input int n, input string tag);
    int ne, efc, efi, h;
    bit ok;
    ne = (n > DEPTH) ? DEPTH : n;
    efc = 0; efi = 0;
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_dut_resetn"}, dut_resetn, 1);
    check({tag, "_nruns"}, hiq.size(), ne);
    check({tag, "_nresets"}, loq.size(), ne);
    for (int v = 0; v < ne; v++) begin
      h = predict(v, ok);
      if (!ok) begin
        if (efc == 0) efi = v;
        efc++;
      end
      if (v < hiq.size()) check($sformatf("%s_runlen%0d", tag, v), hiq[v], h);
      if (v < loq.size()) check($sformatf("%s_rstlen%0d", tag, v), loq[v], RST_CYCLES);
    end
    check({tag, "_fail_count"}, fail_count, efc);
    check({tag, "_fail_index"}, fail_index, efi);
    check({tag, "_pass"}, pass, (efc == 0));
    if (ne > 0) check({tag, "_last_inputs"}, in_port_bus, {m_in1[ne-1], m_in0[ne-1]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; start = 1'b0; ld_we = 1'b0; num_vec = '0;
    ld_addr = '0; ld_sel = '0; ld_data = '0;
    dly[0] = 5; dly[1] = 9; dly[2] = 20;
    repeat (3) @(negedge clock);
    check("rst_in_port_bus", in_port_bus, 0);
    check("rst_dut_resetn", dut_resetn, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail_count", fail_count, 0);
    check("rst_fail_index", fail_index, 0);
    resetn = 1'b1;
    @(negedge clock);

    // Empty run straight from IDLE.
    launch(0);
    check_run(0, "empty");

    // Vector 0: {6,5} -> port 2 shows 11 after 20 cycles.
    load_vec(0, 6, 5, 11, 2);
    launch(1);
    wait_done(200);
    check_run(1, "vec0");

    // Three vectors, the middle one unreachable.
    load_vec(1, 6, 5, 99, 2);
    load_vec(2, 3, 4, f_of(0, 3, 4), 0);
    launch(3);
    wait_done(400);
    check_run(3, "three");

    // Random tables; round 0 puts port 0 on the last allowed cycle and port 1 one past it.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) dly[k] = $urandom_range(1, 70);
      if (r == 0) begin dly[0] = TIMEOUT - 2; dly[1] = TIMEOUT - 1; end
      for (int v = 0; v < DEPTH; v++) rand_vec(v);
      launch((r == 0) ? 20 : (r == 1) ? 16 : $urandom_range(1, 15));
      wait_done(2000);
      check_run((r == 0) ? 20 : (r == 1) ? 16 : int'(num_vec), $sformatf("rand%0d", r));
    end

    // start and table writes during a run are ignored.
    dly[0] = 5; dly[1] = 9; dly[2] = 20;
    load_vec(2, 10, 20, 30, 2);
    launch(3);
    start = 1'b1; num_vec = 5'd1;
    tbl_write(2, 2, 32'h0000_FFFF);
    start = 1'b0; num_vec = 5'd3;
    wait_done(400);
    check_run(3, "busy_ignore");

    // Reset in the middle of RUN, then rerun from the preserved table.
    launch(3);
    for (int i = 0; i < 100 && !dut_resetn; i++) @(negedge clock);
    check("midrun_reached_run", dut_resetn, 1);
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    #1;
    check("midrst_in_port_bus", in_port_bus, 0);
    check("midrst_dut_resetn", dut_resetn, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_pass", pass, 0);
    check("midrst_fail_count", fail_count, 0);
    check("midrst_fail_index", fail_index, 0);
    @(negedge clock);
    resetn = 1'b1;
    launch(3);
    wait_done(400);
    check_run(3, "rerun");

    // Match for 3 cycles, break, then hold.
    glitch_on = 1'b1; glitch_at = 10;
    load_vec(0, 7, 8, 15, 2);
    launch(1);
    wait_done(200);
    check_run(1, "glitch");
    glitch_on = 1'b0;

    // Out-of-range select fails at timeout; next vector still runs.
    load_vec(0, 4, 4, 8, 5);
    load_vec(1, 4, 6, f_of(1, 4, 6), 1);
    launch(2);
    wait_done(300);
    check_run(2, "bad_sel");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
